// File: rtl/tcdm_g_splitter.sv
// Wide-to-narrow TCDM splitter: one SIZE-word request becomes SIZE
// sequential bank accesses, answered by a single wide response.
module tcdm_g_splitter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int SIZE       = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wide_req_i,
    input  logic [ADDR_WIDTH-1:0]      wide_add_i,
    input  logic                       wide_wen_i,
    input  logic [SIZE*DATA_WIDTH-1:0] wide_wdata_i,
    input  logic [SIZE*BE_WIDTH-1:0]   wide_be_i,
    output logic                       wide_gnt_o,
    output logic                       wide_r_valid_o,
    output logic [SIZE*DATA_WIDTH-1:0] wide_r_rdata_o,
    output logic                       tcdm_req_o,
    output logic [ADDR_WIDTH-1:0]      tcdm_add_o,
    output logic                       tcdm_wen_o,
    output logic [DATA_WIDTH-1:0]      tcdm_wdata_o,
    output logic [BE_WIDTH-1:0]        tcdm_be_o,
    input  logic                       tcdm_gnt_i,
    input  logic                       tcdm_r_valid_i,
    input  logic [DATA_WIDTH-1:0]      tcdm_r_rdata_i
);

    localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t                     state;
    logic [ADDR_WIDTH-1:0]      add_q;
    logic                       wen_q;
    logic [SIZE*DATA_WIDTH-1:0] wdata_q;
    logic [SIZE*BE_WIDTH-1:0]   be_q;
    logic [SIZE*DATA_WIDTH-1:0] slots_q;
    logic [SIZE*DATA_WIDTH-1:0] slots_n;
    logic [CW-1:0]              k;
    logic [CW-1:0]              r;
    logic                       issue;
    logic                       rsp;
    logic                       last_rsp;

    assign issue    = (state == ISSUE);
    // Responses only count while a transaction is in flight.
    assign rsp      = tcdm_r_valid_i && (state == ISSUE || state == WAIT);
    assign last_rsp = rsp && (r == LAST);

    assign wide_gnt_o   = rst_n && (state == IDLE) && wide_req_i;
    assign tcdm_req_o   = issue;
    assign tcdm_wen_o   = issue && wen_q;
    assign tcdm_add_o   = issue ? add_q + ADDR_WIDTH'(k) * ADDR_WIDTH'(BE_WIDTH) : '0;
    assign tcdm_wdata_o = issue ? wdata_q[k*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign tcdm_be_o    = issue ? be_q[k*BE_WIDTH +: BE_WIDTH] : '0;

    always_comb begin
        slots_n = slots_q;
        if (rsp) begin
            slots_n[r*DATA_WIDTH +: DATA_WIDTH] = tcdm_r_rdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            add_q          <= '0;
            wen_q          <= 1'b0;
            wdata_q        <= '0;
            be_q           <= '0;
            slots_q        <= '0;
            k              <= '0;
            r              <= '0;
            wide_r_valid_o <= 1'b0;
            wide_r_rdata_o <= '0;
        end else begin
            wide_r_valid_o <= 1'b0;
            slots_q        <= slots_n;
            unique case (state)
                IDLE: begin
                    if (wide_req_i) begin
                        add_q   <= wide_add_i;
                        wen_q   <= wide_wen_i;
                        wdata_q <= wide_wdata_i;
                        be_q    <= wide_be_i;
                        k       <= '0;
                        r       <= '0;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (tcdm_gnt_i) k <= k + CW'(1);
                    if (rsp) r <= r + CW'(1);
                    if (last_rsp) begin
                        state <= RESP;
                    end else if (tcdm_gnt_i && k == LAST) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (rsp) r <= r + CW'(1);
                    if (last_rsp) state <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
            endcase
            // Register the wide response as the final word lands.
            if (last_rsp) begin
                wide_r_valid_o <= 1'b1;
                wide_r_rdata_o <= slots_n;
            end
        end
    end

endmodule
